// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared opcode/funct, ALU control and state encodings for the CPU control units
package cpu_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b100;
    localparam logic [2:0] ALU_AND  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b101;
    localparam logic [2:0] ALU_SLT  = 3'b010;
    localparam logic [2:0] ALU_LUI  = 3'b110;
    localparam logic [2:0] ALU_ZERO = 3'b111;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        ST_IDLE, ST_FETCH, ST_DECODE, ST_MEM_ADR, ST_MEM_RD, ST_MEM_WB, ST_MEM_WR,
        ST_EXEC_R, ST_R_WB, ST_EXEC_I, ST_I_WB, ST_BRANCH, ST_JUMP, ST_TRAP
    } state_e;

    // What the ALU is being used for in the current state
    typedef enum logic [2:0] {
        CLS_NONE, CLS_ADD, CLS_SUB, CLS_RTYPE, CLS_ITYPE
    } alu_cls_e;

endpackage

// File: rtl/alu_ctr_dec.sv
// rtl/alu_ctr_dec.sv - combinational ALU control, immediate extension and legality decode
module alu_ctr_dec
    import cpu_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  alu_cls_e   cls,
    output logic [2:0] alu_ctr,
    output logic       ext_op,
    output logic       legal
);

    logic [2:0] r_alu;
    logic       r_legal;

    always_comb begin
        r_alu   = ALU_ZERO;
        r_legal = 1'b1;
        case (funct)
            FN_ADD:  r_alu = ALU_ADD;
            FN_SUB:  r_alu = ALU_SUB;
            FN_AND:  r_alu = ALU_AND;
            FN_OR:   r_alu = ALU_OR;
            FN_SLT:  r_alu = ALU_SLT;
            default: r_legal = 1'b0;
        endcase
    end

    always_comb begin
        case (opcode)
            OP_RTYPE: legal = r_legal;
            OP_J, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW: legal = 1'b1;
            default:  legal = 1'b0;
        endcase
    end

    always_comb begin
        alu_ctr = ALU_ZERO;
        ext_op  = 1'b0;
        case (cls)
            CLS_ADD: begin
                alu_ctr = ALU_ADD;
                ext_op  = 1'b1;
            end
            CLS_SUB:   alu_ctr = ALU_SUB;
            CLS_RTYPE: alu_ctr = r_alu;
            CLS_ITYPE: begin
                case (opcode)
                    OP_ADDI: begin
                        alu_ctr = ALU_ADD;
                        ext_op  = 1'b1;
                    end
                    OP_ANDI: alu_ctr = ALU_AND;
                    OP_ORI:  alu_ctr = ALU_OR;
                    OP_LUI:  alu_ctr = ALU_LUI;
                    default: alu_ctr = ALU_ZERO;
                endcase
            end
            default: alu_ctr = ALU_ZERO;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle CPU control FSM driving ALU control, mux selects and strobes
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int RESET_PC_HOLD = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [2:0] alu_ctr,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_op,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_en,
    output logic [1:0] pc_src,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       illegal
);

    localparam logic [3:0] HOLD_LAST = 4'(RESET_PC_HOLD);

    state_e     state_q, state_d;
    logic [3:0] hold_cnt_q, hold_cnt_d;
    alu_cls_e   cls;
    logic       legal;
    logic       pc_write;
    logic       pc_write_cond;

    alu_ctr_dec u_alu_ctr_dec (
        .opcode  (opcode),
        .funct   (funct),
        .cls     (cls),
        .alu_ctr (alu_ctr),
        .ext_op  (ext_op),
        .legal   (legal)
    );

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (hold_cnt_q == HOLD_LAST) state_d = ST_FETCH;
                else                         hold_cnt_d = hold_cnt_q + 4'd1;
            end
            ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                if (!legal) state_d = ST_TRAP;
                else begin
                    case (opcode)
                        OP_LW, OP_SW: state_d = ST_MEM_ADR;
                        OP_RTYPE:     state_d = ST_EXEC_R;
                        OP_BEQ:       state_d = ST_BRANCH;
                        OP_J:         state_d = ST_JUMP;
                        default:      state_d = ST_EXEC_I;
                    endcase
                end
            end
            ST_MEM_ADR: state_d = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:  if (mem_ready) state_d = ST_MEM_WB;
            ST_MEM_WR:  if (mem_ready) state_d = ST_FETCH;
            ST_EXEC_R:  state_d = ST_R_WB;
            ST_EXEC_I:  state_d = ST_I_WB;
            ST_MEM_WB, ST_R_WB, ST_I_WB, ST_BRANCH, ST_JUMP: state_d = ST_FETCH;
            default:    state_d = ST_TRAP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    always_comb begin
        case (state_q)
            ST_FETCH, ST_DECODE, ST_MEM_ADR: cls = CLS_ADD;
            ST_EXEC_R: cls = CLS_RTYPE;
            ST_EXEC_I: cls = CLS_ITYPE;
            ST_BRANCH: cls = CLS_SUB;
            default:   cls = CLS_NONE;
        endcase
    end

    // Strobes and selects; anything not named in a state stays at its inactive value
    always_comb begin
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = PCSRC_ALU;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            ST_DECODE: alu_src_b = SRCB_IMM_SH2;
            ST_MEM_ADR, ST_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            ST_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            ST_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            ST_EXEC_R: alu_src_a = 1'b1;
            ST_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            ST_I_WB: reg_write = 1'b1;
            ST_BRANCH: begin
                alu_src_a     = 1'b1;
                pc_write_cond = 1'b1;
                pc_src        = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                pc_src   = PCSRC_JUMP;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    assign pc_en   = pc_write | (pc_write_cond & zero);
    assign illegal = (state_q == ST_TRAP);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

    typedef struct packed {
        logic [2:0] alu;
        logic       a;
        logic [1:0] b;
        logic       ext;
        logic       iord;
        logic       mr;
        logic       mw;
        logic       irw;
        logic       pce;
        logic [1:0] pcs;
        logic       rdst;
        logic       m2r;
        logic       rw;
        logic       ill;
    } outs_t;

    typedef struct {
        outs_t val;
        outs_t care;
        logic  rdy;
        logic  z;
    } cyc_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        int         cycles;
        logic [2:0] alu2;
        logic       alu_care;
        int         n_rw;
        int         n_mw;
        int         n_pce;
    } vec_t;

    localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_J = 5, K_BAD = 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode, funct;
    logic       zero, mem_ready;
    logic [2:0] alu_ctr;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_op, i_or_d, mem_read, mem_write, ir_write, pc_en;
    logic [1:0] pc_src;
    logic       reg_dst, mem_to_reg, reg_write, illegal;
    outs_t      act;

    int checks = 0;
    int failures = 0;
    cyc_t q[$];
    vec_t tbl[14];
    logic [5:0] pool_op[14];
    logic [5:0] pool_fn[14];

    multicycle_ctrl #(.RESET_PC_HOLD(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .alu_ctr    (alu_ctr),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .ext_op     (ext_op),
        .i_or_d     (i_or_d),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .pc_en      (pc_en),
        .pc_src     (pc_src),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    assign act = {alu_ctr, alu_src_a, alu_src_b, ext_op, i_or_d, mem_read, mem_write,
                  ir_write, pc_en, pc_src, reg_dst, mem_to_reg, reg_write, illegal};

    task automatic check(input string name, input outs_t exp, input outs_t care);
        logic [17:0] g, e, m;
        g = act;
        e = exp;
        m = care;
        checks++;
        if (((g ^ e) & m) != 18'd0) begin
            failures++;
            $display("FAIL %s: got=%b required=%b care=%b", name, g, e, m);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got=%0d required=%0d", name, got, exp);
        end
    endtask

    function automatic int kind(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00:   return (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) ? K_R : K_BAD;
            6'h08, 6'h0C, 6'h0D, 6'h0F: return K_I;
            6'h23:   return K_LW;
            6'h2B:   return K_SW;
            6'h04:   return K_BEQ;
            6'h02:   return K_J;
            default: return K_BAD;
        endcase
    endfunction

    function automatic logic [2:0] r_alu(input logic [5:0] fn);
        case (fn)
            6'h20:   return 3'b000;
            6'h22:   return 3'b100;
            6'h24:   return 3'b001;
            6'h25:   return 3'b101;
            default: return 3'b010;
        endcase
    endfunction

    function automatic logic [2:0] i_alu(input logic [5:0] op);
        case (op)
            6'h08:   return 3'b000;
            6'h0C:   return 3'b001;
            6'h0D:   return 3'b101;
            default: return 3'b110;
        endcase
    endfunction

    // Strobes are always checked; selects only where the step defines them
    function automatic cyc_t base();
        cyc_t c;
        c.val  = '0;
        c.care = '0;
        c.care.mr  = 1'b1;
        c.care.mw  = 1'b1;
        c.care.irw = 1'b1;
        c.care.pce = 1'b1;
        c.care.rw  = 1'b1;
        c.care.ill = 1'b1;
        c.rdy = 1'($urandom);
        c.z   = 1'($urandom);
        return c;
    endfunction

    function automatic cyc_t dp(input cyc_t ci, input logic [2:0] alu, input logic a, input logic [1:0] b);
        cyc_t c = ci;
        c.val.alu  = alu;
        c.val.a    = a;
        c.val.b    = b;
        c.care.alu = 3'b111;
        c.care.a   = 1'b1;
        c.care.b   = 2'b11;
        return c;
    endfunction

    task automatic build(input logic [5:0] op, input logic [5:0] fn, input int fst,
                         input int mst, input logic z, input int trap_len);
        cyc_t c;
        int   k;
        for (int i = 0; i <= fst; i++) begin
            c = dp(base(), 3'b000, 1'b0, 2'b01);
            c.rdy = (i == fst);
            c.val.mr  = 1'b1;
            c.val.irw = c.rdy;
            c.val.pce = c.rdy;
            c.care.iord = 1'b1;
            c.care.pcs  = 2'b11;
            q.push_back(c);
        end
        c = dp(base(), 3'b000, 1'b0, 2'b11);
        c.val.ext = 1'b1;
        c.care.ext = 1'b1;
        q.push_back(c);
        k = kind(op, fn);
        case (k)
            K_LW, K_SW: begin
                c = dp(base(), 3'b000, 1'b1, 2'b10);
                c.val.ext = 1'b1;
                c.care.ext = 1'b1;
                q.push_back(c);
                for (int i = 0; i <= mst; i++) begin
                    c = base();
                    c.rdy = (i == mst);
                    if (k == K_LW) c.val.mr = 1'b1;
                    else           c.val.mw = 1'b1;
                    c.val.iord = 1'b1;
                    c.care.iord = 1'b1;
                    q.push_back(c);
                end
                if (k == K_LW) begin
                    c = base();
                    c.val.rw  = 1'b1;
                    c.val.m2r = 1'b1;
                    c.care.m2r  = 1'b1;
                    c.care.rdst = 1'b1;
                    q.push_back(c);
                end
            end
            K_R: begin
                q.push_back(dp(base(), r_alu(fn), 1'b1, 2'b00));
                c = base();
                c.val.rw   = 1'b1;
                c.val.rdst = 1'b1;
                c.care.rdst = 1'b1;
                c.care.m2r  = 1'b1;
                q.push_back(c);
            end
            K_I: begin
                c = dp(base(), i_alu(op), 1'b1, 2'b10);
                if (op != 6'h0F) begin
                    c.val.ext = (op == 6'h08);
                    c.care.ext = 1'b1;
                end
                q.push_back(c);
                c = base();
                c.val.rw = 1'b1;
                c.care.rdst = 1'b1;
                q.push_back(c);
            end
            K_BEQ: begin
                c = dp(base(), 3'b100, 1'b1, 2'b00);
                c.z = z;
                c.val.pcs = 2'b01;
                c.val.pce = z;
                c.care.pcs = 2'b11;
                q.push_back(c);
            end
            K_J: begin
                c = base();
                c.val.pcs = 2'b10;
                c.val.pce = 1'b1;
                c.care.pcs = 2'b11;
                q.push_back(c);
            end
            default: begin
                for (int i = 0; i < trap_len; i++) begin
                    c = base();
                    c.val.ill = 1'b1;
                    c.val.alu = 3'b111;
                    c.care.alu = 3'b111;
                    q.push_back(c);
                end
            end
        endcase
    endtask

    task automatic run_q(input string name);
        cyc_t c;
        while (q.size() != 0) begin
            c = q.pop_front();
            mem_ready = c.rdy;
            zero = c.z;
            #1;
            check(name, c.val, c.care);
            @(negedge clk);
        end
    endtask

    task automatic do_reset(input string name);
        outs_t iv, ic;
        iv = '0;
        iv.alu = 3'b111;
        ic = '1;
        mem_ready = 1'b1;
        zero = 1'b1;
        rst_n = 1'b0;
        #1;
        check({name, "_async"}, iv, ic);
        @(negedge clk);
        #1;
        check({name, "_held"}, iv, ic);
        rst_n = 1'b1;
        #1;
        check({name, "_release"}, iv, ic);
        @(negedge clk);
        #1;
        check({name, "_idle"}, iv, ic);
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n = 0, rw = 0, mw = 0, pce = 0;
        logic [2:0] alu2 = 3'b000;
        bit done = 1'b0;
        string nm;
        nm = $sformatf("vec%0d", idx);
        opcode = v.op;
        funct = v.fn;
        zero = v.z;
        mem_ready = 1'b1;
        for (int i = 0; i < 12 && !done; i++) begin
            #1;
            if (i == 2) alu2 = alu_ctr;
            if (i > 0 && ir_write) begin
                n = i;
                done = 1'b1;
            end else begin
                rw  += int'(reg_write);
                mw  += int'(mem_write);
                pce += int'(pc_en);
                @(negedge clk);
            end
        end
        chk_int({nm, "_cycles"}, n, v.cycles);
        if (v.alu_care) chk_int({nm, "_alu_ctr"}, int'(alu2), int'(v.alu2));
        chk_int({nm, "_reg_write_pulses"}, rw, v.n_rw);
        chk_int({nm, "_mem_write_pulses"}, mw, v.n_mw);
        chk_int({nm, "_pc_en_pulses"}, pce, v.n_pce);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        outs_t fv, fc;
        logic [5:0] op, fn;
        int pick;

        tbl[0]  = '{6'h00, 6'h20, 1'b0, 4, 3'b000, 1'b1, 1, 0, 1};
        tbl[1]  = '{6'h00, 6'h22, 1'b1, 4, 3'b100, 1'b1, 1, 0, 1};
        tbl[2]  = '{6'h00, 6'h24, 1'b0, 4, 3'b001, 1'b1, 1, 0, 1};
        tbl[3]  = '{6'h00, 6'h25, 1'b1, 4, 3'b101, 1'b1, 1, 0, 1};
        tbl[4]  = '{6'h00, 6'h2A, 1'b0, 4, 3'b010, 1'b1, 1, 0, 1};
        tbl[5]  = '{6'h08, 6'h3F, 1'b0, 4, 3'b000, 1'b1, 1, 0, 1};
        tbl[6]  = '{6'h0C, 6'h3F, 1'b1, 4, 3'b001, 1'b1, 1, 0, 1};
        tbl[7]  = '{6'h0D, 6'h00, 1'b0, 4, 3'b101, 1'b1, 1, 0, 1};
        tbl[8]  = '{6'h0F, 6'h27, 1'b1, 4, 3'b110, 1'b1, 1, 0, 1};
        tbl[9]  = '{6'h23, 6'h00, 1'b1, 5, 3'b000, 1'b1, 1, 0, 1};
        tbl[10] = '{6'h2B, 6'h00, 1'b1, 4, 3'b000, 1'b1, 0, 1, 1};
        tbl[11] = '{6'h04, 6'h00, 1'b1, 3, 3'b100, 1'b1, 0, 0, 2};
        tbl[12] = '{6'h04, 6'h00, 1'b0, 3, 3'b100, 1'b1, 0, 0, 1};
        tbl[13] = '{6'h02, 6'h00, 1'b0, 3, 3'b000, 1'b0, 0, 0, 2};

        pool_op = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h0C,
                    6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h04, 6'h02};
        pool_fn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h00,
                    6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

        opcode = 6'h00;
        funct = 6'h00;
        do_reset("reset");

        // Second cycle after release must be a completing fetch
        fv = '0;
        fc = '0;
        fv.irw = 1'b1;
        fv.pce = 1'b1;
        fv.mr  = 1'b1;
        fc.irw = 1'b1;
        fc.pce = 1'b1;
        fc.mr  = 1'b1;
        fc.rw  = 1'b1;
        fc.mw  = 1'b1;
        #1;
        check("first_fetch", fv, fc);

        for (int i = 0; i < 14; i++) run_vec(tbl[i], i);

        opcode = 6'h23;
        funct = 6'h00;
        build(6'h23, 6'h00, 0, 3, 1'b0, 0);
        run_q("lw_stall");

        opcode = 6'h2B;
        build(6'h2B, 6'h00, 2, 2, 1'b1, 0);
        run_q("sw_stall");

        opcode = 6'h3F;
        funct = 6'h20;
        build(6'h3F, 6'h20, 0, 0, 1'b0, 20);
        run_q("trap_op3f");
        do_reset("trap_op3f_reset");

        opcode = 6'h00;
        funct = 6'h27;
        build(6'h00, 6'h27, 1, 0, 1'b0, 20);
        run_q("trap_fn27");
        do_reset("trap_fn27_reset");

        for (int t = 0; t < 60; t++) begin
            pick = $urandom_range(0, 15);
            if (pick < 14) begin
                op = pool_op[pick];
                fn = (op == 6'h00) ? pool_fn[pick] : 6'($urandom);
            end else begin
                op = 6'($urandom);
                fn = 6'($urandom);
                for (int g = 0; g < 100 && kind(op, fn) != K_BAD; g++) begin
                    op = 6'($urandom);
                    fn = 6'($urandom);
                end
            end
            opcode = op;
            funct = fn;
            build(op, fn, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom), 3);
            run_q($sformatf("rand%0d_op%02h_fn%02h", t, op, fn));
            if (kind(op, fn) == K_BAD) do_reset($sformatf("rand%0d_reset", t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Control unit for the multi-cycle CPU datapath; it is the initiator on the ALU's control interface.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives alu_ctr plus every datapath mux select and write strobe.
- Consumes the opcode and funct fields from the instruction register, the ALU zero flag, and a memory ready handshake.

Parameters:
- RESET_PC_HOLD, 1, number of IDLE cycles after reset release before the first FETCH (range 1-15).

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  instruction bits [31:26] from the IR.
- funct  in  6  instruction bits [5:0] from the IR.
- zero  in  1  ALU Zero flag.
- mem_ready  in  1  memory completes the current read/write this cycle.
- alu_ctr  out  3  ALU operation: 000 add, 100 sub, 001 and, 101 or, 010 slt (signed), 110 B<<16, 111 result zero.
- alu_src_a  out  1  0 selects PC, 1 selects register A.
- alu_src_b  out  2  00 register B, 01 constant 4, 10 extended immediate, 11 extended immediate<<2.
- ext_op  out  1  1 sign-extend immediate, 0 zero-extend.
- i_or_d  out  1  memory address source: 0 PC, 1 ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load strobe.
- pc_en  out  1  PC load, equal to pc_write | (pc_write_cond & zero).
- pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- reg_dst  out  1  destination register: 0 rt, 1 rd.
- mem_to_reg  out  1  writeback data: 0 ALUOut, 1 MDR.
- reg_write  out  1  register file write strobe.
- illegal  out  1  sticky; unsupported instruction decoded.

Behaviour:
- Reset: asynchronous. State goes to IDLE and all outputs are 0, except alu_ctr=111. The IDLE counter is cleared. Reset asserted mid-instruction aborts it immediately; no strobe fires afterwards.
- Outputs are Moore (a function of state, opcode and funct). pc_en also uses zero. Outputs are combinational from registered state.
- Supported instructions:
  - R-type (opcode 000000): funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt.
  - addi 0x08, andi 0x0C, ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B, beq 0x04, j 0x02.
- IDLE: alu_ctr=111, no strobes. Moves to FETCH after RESET_PC_HOLD cycles.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_ctr=000, pc_src=00.
  - While mem_ready=0: hold in FETCH; ir_write=0, pc_en=0.
  - When mem_ready=1: ir_write=1 and pc_write=1 in that cycle only; go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, ext_op=1, alu_ctr=000 (branch target computed). Next state by opcode:
  - lw/sw go to MEM_ADR.
  - R-type with legal funct goes to EXEC_R.
  - addi/andi/ori/lui go to EXEC_I.
  - beq goes to BRANCH; j goes to JUMP.
  - Anything else goes to TRAP.
- MEM_ADR: alu_src_a=1, alu_src_b=10, ext_op=1, alu_ctr=000. lw goes to MEM_RD, sw goes to MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1. Waits on mem_ready, then goes to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; then FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Waits on mem_ready, then goes to FETCH. mem_write stays high through the wait.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_ctr from funct; then R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0; then FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10.
  - addi: 000, ext_op=1.
  - andi: 001, ext_op=0.
  - ori: 101, ext_op=0.
  - lui: 110.
  - Then I_WB.
- I_WB: reg_write=1, reg_dst=0; then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_ctr=100, pc_write_cond=1, pc_src=01, so pc_en=zero; then FETCH.
- JUMP: pc_src=10, pc_en=1; then FETCH.
- TRAP: illegal=1, alu_ctr=111, all strobes 0. Absorbing; only reset exits.
- Cycle counts from FETCH entry with mem_ready always 1: lw 5, sw 4, R 4, I 4, beq 3, j 3.
- At most one of reg_write/mem_write/ir_write is high in any cycle.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - opcode and funct localparams;
  - ALU_Ctr encodings (ALU_ADD..ALU_ZERO), shared with the ALU;
  - the alu_src_b and pc_src encodings;
  - the state enumeration (4-bit binary).
- One sub-module, alu_ctr_dec, is combinational: opcode/funct/state-class in, alu_ctr, ext_op and legal out. It is reused by the single-cycle variant.

Test Plan:
- Reset asserted, mem_ready=1, RESET_PC_HOLD=1 → all strobes 0 and alu_ctr=111 during reset and IDLE; ir_write=1 and pc_en=1 exactly 2 cycles after release.
- opcode=0, funct=0x22, mem_ready=1 → states FETCH, DECODE, EXEC_R (alu_ctr=100), R_WB (reg_write=1, reg_dst=1); back in FETCH on the 5th cycle.
- lw (0x23) with mem_ready low 3 cycles in MEM_RD → mem_read and i_or_d held high 4 cycles, reg_write=0 until MEM_WB, mem_to_reg=1; 8 cycles total.
- beq (0x04): zero=1 in BRANCH gives pc_en=1, pc_src=01; repeat with zero=0 gives pc_en=0; both return to FETCH.
- ori (0x0D) → ext_op=0, alu_ctr=101. lui (0x0F) → alu_ctr=110. andi (0x0C) → alu_ctr=001.
- opcode=0x3F, and opcode=0 with funct=0x27 → TRAP, illegal=1 held for 20 cycles with no strobes; rst_n pulsed mid-TRAP clears illegal asynchronously.
